// File: rtl/mmio_video_bridge.sv
// Memory-mapped store FIFO between the CPU data port and the VGA image-word input.
// Optional feature: define MMIO_BRIDGE_DROPCNT_EN for a saturating dropped-write counter at status[23:16].
module mmio_video_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 8,
  parameter int          CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wEn,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  input  logic        image_ready,
  output logic        image_valid,
  output logic [31:0] image_word
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [7:0]       drop_cnt;
  logic [7:0]       count_ext;

  logic pix_sel;
  logic stat_sel;
  logic ctl_sel;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;
  logic clr;

  assign pix_sel  = (addr == BASE_ADDR);
  assign stat_sel = (addr == BASE_ADDR + 32'd4);
  assign ctl_sel  = (addr == BASE_ADDR + 32'd8);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A pop frees a slot on the same edge, so a store into a full FIFO is still accepted then.
  assign pop  = image_ready && !empty;
  assign push = wEn && pix_sel && (!full || pop);
  assign drop = wEn && pix_sel && full && !pop;
  assign clr  = wEn && ctl_sel && dataIn[0];

  assign image_valid = !empty;
  assign count_ext   = 8'(count);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  // Clear wins over pointer/count movement, but a same-cycle pop still delivers its word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      image_word <= 32'h0;
    end else begin
      if (pop) begin
        image_word <= mem[rd_ptr];
      end
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
        if (drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef MMIO_BRIDGE_DROPCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= 8'h00;
    end else if (clr) begin
      drop_cnt <= 8'h00;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = 8'h00;
`endif

  always_comb begin
    dataOut = 32'h0;
    if (stat_sel) begin
      dataOut = {8'h00, drop_cnt, count_ext, 5'b00000, overflow, empty, full};
    end
  end

endmodule

// File: tb/tb_mmio_video_bridge.sv
// Scoreboard bench for mmio_video_bridge: stimulus queues expected drained words, a monitor checks each pop.
module tb_mmio_video_bridge;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam logic [31:0] CTRL = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wEn;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        image_ready;
  logic        image_valid;
  logic [31:0] image_word;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] drop_field;

  always #5 clk = ~clk;

  mmio_video_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .wEn         (wEn),
    .addr        (addr),
    .dataIn      (dataIn),
    .dataOut     (dataOut),
    .image_ready (image_ready),
    .image_valid (image_valid),
    .image_word  (image_word)
  );

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs from a negedge, then return to idle at the next negedge.
  task automatic apply_stimulus(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    wEn         = we;
    addr        = a;
    dataIn      = d;
    image_ready = rdy;
    @(negedge clk);
    wEn         = 1'b0;
    addr        = STAT;
    dataIn      = 32'h0;
    image_ready = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [31:0] want);
    addr = STAT;
    #1;
    check_output(name, dataOut, want);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, STAT, 32'h0, 1'b1);
  endtask

  // Monitor: every accepted pop must deliver the oldest expected word.
  always @(posedge clk) begin
    if (!reset && image_ready && image_valid) begin
      #1;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_pop: got %h, expected no pop", image_word);
      end else begin
        check_output("image_word", image_word, exp_q.pop_front());
      end
    end
  end

  initial begin
`ifdef MMIO_BRIDGE_DROPCNT_EN
    drop_field = 32'h00FF_0000;
`else
    drop_field = 32'h0000_0000;
`endif
    reset       = 1'b1;
    wEn         = 1'b0;
    addr        = STAT;
    dataIn      = 32'h0;
    image_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_status("reset_status", 32'h0000_0002);
    check_output("reset_valid", {31'h0, image_valid}, 32'h0);
    check_output("reset_word", image_word, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single store, show-ahead valid, then one pop.
    apply_stimulus(1'b1, BASE, 32'hA5A5_0001, 1'b0);
    check_output("valid_after_push", {31'h0, image_valid}, 32'h1);
    check_status("status_one", 32'h0000_0100);
    exp_q.push_back(32'hA5A5_0001);
    drain(1);
    check_output("valid_after_pop", {31'h0, image_valid}, 32'h0);

    // Fill, overflow with 0xDEAD, drain 0..7.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, BASE, 32'(i), 1'b0);
    apply_stimulus(1'b1, BASE, 32'h0000_DEAD, 1'b0);
    check_status("status_overflow", 32'h0000_0805);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
    drain(8);
    check_status("status_drained", 32'h0000_0006);
    drain(1);
    check_output("empty_ready_holds", image_word, 32'h7);

    // Control write with bit0 clear does nothing; with bit0 set clears overflow.
    apply_stimulus(1'b1, CTRL, 32'h0000_0000, 1'b0);
    check_status("ctrl_zero_noop", 32'h0000_0006);
    apply_stimulus(1'b1, CTRL, 32'h0000_0001, 1'b0);
    check_status("ctrl_clear", 32'h0000_0002);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, BASE, 32'(i), 1'b0);
    check_status("status_full", 32'h0000_0801);
    exp_q.push_back(32'h0);
    apply_stimulus(1'b1, BASE, 32'h9, 1'b1);
    check_status("full_push_pop", 32'h0000_0801);
    for (int i = 1; i < 8; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'h9);
    drain(8);
    check_status("status_after_drain", 32'h0000_0002);

    // Push and ready together while empty: no bypass.
    apply_stimulus(1'b1, BASE, 32'h55, 1'b1);
    check_status("empty_push_ready", 32'h0000_0100);
    check_output("no_bypass_word", image_word, 32'h9);
    exp_q.push_back(32'h55);
    drain(1);

    // Clear with three queued words keeps image_word.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, BASE, 32'h60 + 32'(i), 1'b0);
    apply_stimulus(1'b1, CTRL, 32'h1, 1'b0);
    check_status("clear_three", 32'h0000_0002);
    check_output("clear_keeps_word", image_word, 32'h55);

    // Clear coinciding with a pop: pop still delivers.
    apply_stimulus(1'b1, BASE, 32'h71, 1'b0);
    apply_stimulus(1'b1, BASE, 32'h72, 1'b0);
    exp_q.push_back(32'h71);
    apply_stimulus(1'b1, CTRL, 32'h1, 1'b1);
    check_status("clear_with_pop", 32'h0000_0002);

    // Other address reads zero; writes to status are ignored.
    addr = BASE + 32'd12;
    #1;
    check_output("unmapped_read", dataOut, 32'h0);
    apply_stimulus(1'b1, STAT, 32'hFFFF_FFFF, 1'b0);
    check_status("status_write_ignored", 32'h0000_0002);

    // 300 dropped writes while full.
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, BASE, 32'h80 + 32'(i), 1'b0);
    for (int i = 0; i < 300; i++) apply_stimulus(1'b1, BASE, 32'hBAD, 1'b0);
    check_status("drop_count", drop_field | 32'h0000_0805);
    apply_stimulus(1'b1, CTRL, 32'h1, 1'b0);
    check_status("drop_count_cleared", 32'h0000_0002);

    // Reset mid-stream with three entries queued.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, BASE, 32'h90 + 32'(i), 1'b0);
    check_status("pre_reset_count", 32'h0000_0300);
    reset = 1'b1;
    check_status("midstream_reset_status", 32'h0000_0002);
    check_output("midstream_reset_word", image_word, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mmio_video_bridge.md
Name: mmio_video_bridge

Overview:
- Memory-mapped store buffer between the processor data-memory port and the VGA image-word input.
- CPU stores to the pixel register are queued in a FIFO and drained on a ready/valid handshake from the video side.
- The last drained word is held in a register, so the VGA block always sees a stable image_word.
- Exposes a status register (full/empty/overflow/count) and a control register (clear) on the same bus.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of the pixel register. Status is at BASE_ADDR+4, control at BASE_ADDR+8.
- DEPTH, 8: FIFO entries; must be a power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy counter.

Ports:
- clk  in  1  system clock (100 MHz domain shared with VGA)
- reset  in  1  asynchronous, active-high reset
- wEn  in  1  processor store enable
- addr  in  32  processor byte address
- dataIn  in  32  processor store data
- dataOut  out  32  read data (combinational)
- image_ready  in  1  video side consumes the head word this cycle
- image_valid  out  1  FIFO non-empty
- image_word  out  32  registered last-drained word, fed to VGA

Behaviour:
- Reset (async assert, sync release) clears:
  - read/write pointers = 0, count = 0, overflow = 0, image_word = 0
  - image_valid = 0, and dataOut at the status address reads 32'h0000_0002.
- Address decode uses a full 32-bit equality compare. Non-matching addresses are ignored.
- Push: wEn=1 and addr==BASE_ADDR and (not full, or a pop occurs in the same cycle).
  - The entry is written at the write pointer and the pointer increments modulo DEPTH.
- Drop: a pixel write while full with no same-cycle pop.
  - Data is discarded and sticky overflow is set to 1 on the next edge.
- Pop: image_ready=1 and count>0.
  - image_word <= head entry on that edge; the read pointer increments modulo DEPTH.
  - image_ready while empty has no effect, and image_word holds its value.
- image_valid = (count != 0). It is show-ahead: a word pushed at edge N gives image_valid=1 after edge N.
- There is no empty bypass. A push and an image_ready in the same cycle while empty: the push is stored, no pop occurs, and count becomes 1.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged and both pointers advance.
- Simultaneous push and pop while full: both are accepted, count stays DEPTH, and no overflow is flagged.
- Control write: wEn=1 and addr==BASE_ADDR+8 with dataIn[0]=1.
  - Clears pointers, count and overflow on the next edge. image_word is NOT cleared.
  - dataIn[0]=0 has no effect.
- Clear in the same cycle as a pop: clear wins and image_word still updates with the popped word.
- A push cannot coincide with a clear, because there is a single address per cycle.
- Status read: addr==BASE_ADDR+4 (wEn is ignored for reads) returns:
  - [0] full (count==DEPTH)
  - [1] empty
  - [2] overflow
  - [15:8] count, zero-extended
  - [23:16] drop counter (see Optional Feature)
  - all other bits 0.
- Any other address reads 32'h0. Writes to the status address are ignored.
- Latency from store to image_word: minimum 2 edges (push edge, then pop edge).

Optional Feature:
- MMIO_BRIDGE_DROPCNT_EN
- Defined:
  - 8-bit drop counter, incremented on every dropped write and saturating at 8'hFF.
  - Cleared by reset and by control clear; readable at status[23:16].
  - A drop on the same edge as a clear is not counted.
- Undefined: no counter logic, and status[23:16] reads 0.

Test Plan:
- Reset with no traffic -> status read = 32'h0000_0002, image_valid=0, image_word=0. Assert reset mid-stream with 3 entries queued -> status returns to 32'h0000_0002 immediately and image_word = 0.
- Store 32'hA5A5_0001 to BASE_ADDR, image_ready=0 -> image_valid=1 after 1 edge and status = 32'h0000_0100. Pulse image_ready -> image_word=32'hA5A5_0001 on the next edge and image_valid=0.
- Fill 8 words (0..7), then a 9th store 32'hDEAD -> status = 32'h0000_0805 (full, overflow, count 8). Drain all -> image_word sequence 0..7, with 32'hDEAD never output.
- With the FIFO full, store 32'h9 and assert image_ready in the same cycle -> image_word=0, count stays 8, overflow stays 0. A later drain yields 1..7 then 9.
- Queue 3 words, then write 1 to BASE_ADDR+8 -> status = 32'h0000_0002, and image_word keeps its prior value.
- With MMIO_BRIDGE_DROPCNT_EN, make 300 writes while full -> status[23:16]=8'hFF. A clear then sets it to 0. Without the macro, status[23:16]=0 throughout.
